fib_ctrl: RTL

FIB_CTRL -- requirements
Module: fib_ctrl

---
 rtl/fib_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fib_ctrl.sv
// fib_ctrl: control FSM that sequences an external fibonacci datapath (load n, init, run, hand off result).
// Defining FIB_CTRL_TIMEOUT_EN adds a RUN cycle counter and an ABORT state for runs that never see stop.
module fib_ctrl #(
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] n,
  input  logic                 stop,
  input  logic [BUS_WIDTH-1:0] fib_value,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 select,
  output logic                 en_reg1,
  output logic                 en_reg2,
  output logic                 en_count,
  output logic                 en_n,
  output logic [BUS_WIDTH-1:0] n_out,
  output logic                 res_valid,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic                 err_next_s;
  logic [BUS_WIDTH-1:0] n_r;
  logic [BUS_WIDTH-1:0] result_r;
  logic                 err_r;

`ifdef FIB_CTRL_TIMEOUT_EN
  localparam int            CW          = BUS_WIDTH + 1;
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] COUNT_ONE   = CW'(1);

  logic [CW-1:0] count_r;

  // RUN cycle counter: zeroed during INIT so the first RUN cycle reads 0, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (state_r == INIT) begin
      count_r <= {CW{1'b0}};
    end else if ((state_r == RUN) && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end
  end
`else
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  // Next-state logic; err_next_s flags a rejected start or entry into ABORT.
  always_comb begin
    next_state_s = state_r;
    err_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (n != {BUS_WIDTH{1'b0}}) begin
            next_state_s = LOAD;
          end else begin
            err_next_s = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: next_state_s = INIT;
      INIT: next_state_s = RUN;
      RUN: begin
        if (stop) begin
          next_state_s = DONE;
`ifdef FIB_CTRL_TIMEOUT_EN
        end else if (count_r >= TIMEOUT_LIM) begin
          next_state_s = ABORT;
          err_next_s   = 1'b1;
`endif
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      ABORT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath control decode from the state register; in RUN the stop cycle freezes the datapath.
  always_comb begin
    select   = 1'b0;
    en_reg1  = 1'b0;
    en_reg2  = 1'b0;
    en_count = 1'b0;
    en_n     = 1'b0;
    case (state_r)
      LOAD: en_n = 1'b1;
      INIT: begin
        select   = 1'b1;
        en_reg1  = 1'b1;
        en_reg2  = 1'b1;
        en_count = 1'b1;
      end
      RUN: begin
        if (!stop) begin
          en_reg1  = 1'b1;
          en_reg2  = 1'b1;
          en_count = 1'b1;
        end else begin
          en_reg1  = 1'b0;
          en_reg2  = 1'b0;
          en_count = 1'b0;
        end
      end
      default: select = 1'b0;
    endcase
  end

  // State, latched n, captured result and the err pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      n_r      <= {BUS_WIDTH{1'b0}};
      result_r <= {BUS_WIDTH{1'b0}};
      err_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      err_r   <= err_next_s;
      if ((state_r == IDLE) && (next_state_s == LOAD)) begin
        n_r <= n;
      end
      if ((state_r == RUN) && (next_state_s == DONE)) begin
        result_r <= fib_value;
      end
    end
  end

  assign busy      = (state_r != IDLE);
  assign res_valid = (state_r == DONE);
  assign n_out     = n_r;
  assign result    = result_r;
  assign err       = err_r;

endmodule
